// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_drain
// Purpose  : Ping-pong tile buffer for systolic array result rows, streamed
//            out row-major over a valid/ready interface.
// Revision : 1.0
// ============================================================================
module systolic_result_drain #(
    parameter  int ARRAY_SIZE = 8,
    parameter  int DATA_WIDTH = 8,
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + ARRAY_SIZE,
    localparam int IDX_W      = $clog2(ARRAY_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_in,
    input  logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] c_inputs,
    output logic                                 ready_out,
    output logic [ACC_WIDTH-1:0]                 m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [IDX_W-1:0]                     m_row,
    output logic [IDX_W-1:0]                     m_col,
    output logic                                 m_last,
    output logic                                 overflow,
    input  logic                                 clear_overflow,
    output logic [15:0]                          tiles_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_row_q, rd_row_d;
    logic [IDX_W-1:0] rd_col_q, rd_col_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      tiles_done_q, tiles_done_d;

    logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] bank_mem [2][ARRAY_SIZE];

    logic w_row_acc;
    logic w_row_drop;
    logic w_rd_valid;
    logic w_rd_last;
    logic w_rd_hs;

    assign ready_out  = !full_q[wr_bank_q];
    assign w_row_acc  = valid_in && ready_out;
    assign w_row_drop = valid_in && !ready_out;
    assign w_rd_valid = full_q[rd_bank_q];
    assign w_rd_last  = w_rd_valid && (rd_row_q == LAST_IDX) && (rd_col_q == LAST_IDX);
    assign w_rd_hs    = w_rd_valid && m_ready;

    assign m_valid    = w_rd_valid;
    assign m_data     = w_rd_valid ? bank_mem[rd_bank_q][rd_row_q][rd_col_q] : '0;
    assign m_row      = rd_row_q;
    assign m_col      = rd_col_q;
    assign m_last     = w_rd_last;
    assign overflow   = overflow_q;
    assign tiles_done = tiles_done_q;

    // The write side only targets an empty bank and the read side only a full
    // one, so the set and clear of full_d never collide on the same bank.
    always_comb begin
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        wr_row_d     = wr_row_q;
        rd_bank_d    = rd_bank_q;
        rd_row_d     = rd_row_q;
        rd_col_d     = rd_col_q;
        tiles_done_d = tiles_done_q;
        overflow_d   = overflow_q;

        if (w_row_acc) begin
            if (wr_row_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_row_d          = '0;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
        end

        if (w_rd_hs) begin
            if (w_rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_row_d          = '0;
                rd_col_d          = '0;
                tiles_done_d      = tiles_done_q + 16'd1;
            end else if (rd_col_q == LAST_IDX) begin
                rd_col_d = '0;
                rd_row_d = rd_row_q + 1'b1;
            end else begin
                rd_col_d = rd_col_q + 1'b1;
            end
        end

        if (w_row_drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            wr_row_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            overflow_q   <= 1'b0;
            tiles_done_q <= '0;
        end else begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            wr_row_q     <= wr_row_d;
            rd_bank_q    <= rd_bank_d;
            rd_row_q     <= rd_row_d;
            rd_col_q     <= rd_col_d;
            overflow_q   <= overflow_d;
            tiles_done_q <= tiles_done_d;
        end
    end

    // Tile storage is deliberately left unreset; the full flags qualify it.
    always_ff @(posedge clk) begin
        if (w_row_acc) begin
            bank_mem[wr_bank_q][wr_row_q] <= c_inputs;
        end
    end

endmodule
`default_nettype wire
